// File: rtl/instr_encoder.sv
// Instruction encoder: it encodes source instructions into 9-bit words,
// buffers them in a small FIFO and writes them to sequential
// instruction-memory addresses. Loading stops when a halt is written.
// Loading also stops when an illegal opcode is accepted, or when the
// 256-word address space is exhausted.
module instr_encoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_op,
    input  logic [1:0] in_ra,
    input  logic [1:0] in_rb,
    input  logic [3:0] in_imm,
    output logic       imem_we,
    output logic [7:0] imem_addr,
    output logic [8:0] imem_wdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [4:0] OP_RSADR = 5'b00101;
    localparam logic [4:0] OP_SETI  = 5'b00110;
    localparam logic [4:0] OP_RSCNT = 5'b01110;
    localparam logic [4:0] OP_JUMP  = 5'b11000;
    localparam logic [4:0] OP_HALT  = 5'b11010;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE, S_ERR} state_t;

    state_t        state, state_nxt;
    logic [1:0]    err_code_q;

    logic [8:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    // Bit 8 of the write address is set once all 256 locations are used
    logic [8:0]    wr_addr;

    logic [8:0]    enc_word;
    logic          op_illegal;
    logic          fifo_full, fifo_empty, active;
    logic          accept, acc_illegal, push, pop, store, take;
    logic          start_load, written_halt, overflow;
    logic [8:0]    pop_word;

    // Encode the incoming instruction by opcode class
    always_comb begin
        enc_word   = {in_op, 4'b0000};
        op_illegal = 1'b0;
        if (in_op > OP_HALT)
            op_illegal = 1'b1;
        else if (in_op == OP_SETI || in_op == OP_JUMP)
            enc_word[3:0] = in_imm;
        else if (in_op == OP_RSADR)
            enc_word[3:0] = {3'b000, in_imm[0]};
        else if (in_op == OP_RSCNT || in_op == OP_HALT)
            enc_word[3:0] = 4'b0000;
        else
            enc_word[3:0] = {in_ra, in_rb};
    end

    // Handshake, FIFO push/pop decisions and write-back observation
    always_comb begin
        fifo_full    = (count == CW'(FIFO_DEPTH));
        fifo_empty   = (count == '0);
        active       = (state == S_LOAD) || (state == S_DRAIN);
        start_load   = start && !active;
        accept       = in_valid && in_ready;
        acc_illegal  = accept && op_illegal;
        push         = accept && !op_illegal;
        // An illegal accept suppresses the pop so nothing is written after it
        pop          = active && !acc_illegal && !wr_addr[8] && (!fifo_empty || push);
        // When the FIFO is empty the new word bypasses storage for N+1 write
        take         = pop && !fifo_empty;
        store        = push && !(pop && fifo_empty);
        pop_word     = fifo_empty ? enc_word : fifo_mem[rd_ptr];
        written_halt = imem_we && (imem_wdata[8:4] == OP_HALT);
        overflow     = imem_we && (imem_addr == 8'hFF) && !written_halt;
    end

    // FSM state register; the error cause is latched on ERR entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            err_code_q <= 2'b00;
        end else begin
            state <= state_nxt;
            if (state_nxt == S_ERR && state != S_ERR)
                err_code_q <= overflow ? 2'b10 : 2'b01;
        end
    end

    // FSM next-state logic; overflow takes priority over other exits
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                if (overflow || acc_illegal)       state_nxt = S_ERR;
                else if (push && in_op == OP_HALT) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (overflow)          state_nxt = S_ERR;
                else if (written_halt) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = (state == S_LOAD) && !fifo_full;
        busy     = active;
        done     = (state == S_DONE);
        err      = (state == S_ERR);
        err_code = (state == S_ERR) ? err_code_q : 2'b00;
    end

    // FIFO pointers and occupancy; cleared on reset and on a new load
    always_ff @(posedge clk) begin
        if (!rst_n || start_load) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (store)
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (take)
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (store && !take)
                count <= count + 1'b1;
            else if (take && !store)
                count <= count - 1'b1;
        end
    end

    // FIFO storage; contents are qualified by the pointers, so no reset
    always_ff @(posedge clk) begin
        if (store)
            fifo_mem[wr_ptr] <= enc_word;
    end

    // Registered instruction-memory write port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_addr  <= 8'h00;
            imem_wdata <= 9'h000;
            wr_addr    <= 9'h000;
        end else if (start_load) begin
            imem_we   <= 1'b0;
            imem_addr <= 8'h00;
            wr_addr   <= 9'h000;
        end else begin
            imem_we <= pop;
            if (pop) begin
                imem_addr  <= wr_addr[7:0];
                imem_wdata <= pop_word;
                wr_addr    <= wr_addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a queue-based reference model is
// compared against the DUT every cycle, plus literal expectations for
// hand-computed programs.
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] in_op = '0;
    logic [1:0] in_ra = '0;
    logic [1:0] in_rb = '0;
    logic [3:0] in_imm = '0;
    logic       imem_we;
    logic [7:0] imem_addr;
    logic [8:0] imem_wdata;
    logic       busy, done, err;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: 0 idle, 1 load, 2 drain, 3 done, 4 err
    int         m_mode = 0;
    logic [8:0] m_q[$];
    int         m_addr = 0;
    bit         m_we = 0;
    logic [7:0] m_waddr = '0;
    logic [8:0] m_wdata = '0;
    logic [1:0] m_code = '0;

    function automatic logic [8:0] enc_ref(logic [4:0] op, logic [1:0] ra, logic [1:0] rb, logic [3:0] imm);
        int o;
        o = op;
        if (o == 6 || o == 24) return {op, imm};
        if (o == 5)            return {op, 3'b000, imm[0]};
        if (o == 14 || o == 26) return {op, 4'b0000};
        return {op, ra, rb};
    endfunction

    always @(posedge clk) begin : model_p
        bit rdy, acc, ill;
        int nm;
        cyc++;
        rdy = (m_mode == 1) && (m_q.size() < DEPTH);
        if (!rst_n) begin
            m_mode = 0; m_q.delete(); m_addr = 0;
            m_we = 0; m_waddr = '0; m_wdata = '0; m_code = '0;
            chk_en = 1;
        end else if ((m_mode == 0 || m_mode >= 3) && start) begin
            m_mode = 1; m_q.delete(); m_addr = 0; m_we = 0; m_waddr = '0;
        end else if (m_mode == 1 || m_mode == 2) begin
            acc = in_valid && rdy;
            ill = acc && (in_op > 26);
            nm  = m_mode;
            if (acc && !ill) begin
                m_q.push_back(enc_ref(in_op, in_ra, in_rb, in_imm));
                if (in_op == 26) nm = 2;
            end
            if (m_we && m_waddr == 8'd255 && m_wdata[8:4] != 5'd26) begin
                nm = 4; m_code = 2'b10;
            end else if (ill) begin
                nm = 4; m_code = 2'b01;
            end else if (m_mode == 2 && m_we && m_wdata[8:4] == 5'd26) begin
                nm = 3;
            end
            m_we = 0;
            if (!ill && m_q.size() > 0 && m_addr < 256) begin
                m_wdata = m_q.pop_front();
                m_waddr = 8'(m_addr);
                m_addr++;
                m_we = 1;
            end
            if (nm >= 3) m_q.delete();
            m_mode = nm;
        end else begin
            m_we = 0;
        end
    end

    logic [16:0] wlog[$];
    int          wcyc[$];

    // Every-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",   in_ready,   (m_mode == 1) && (m_q.size() < DEPTH));
            chk("imem_we",    imem_we,    m_we);
            chk("imem_addr",  imem_addr,  m_waddr);
            chk("imem_wdata", imem_wdata, m_wdata);
            chk("busy",       busy,       (m_mode == 1 || m_mode == 2));
            chk("done",       done,       (m_mode == 3));
            chk("err",        err,        (m_mode == 4));
            chk("err_code",   err_code,   (m_mode == 4) ? m_code : 2'b00);
        end
        if (imem_we === 1'b1) begin
            wlog.push_back({imem_addr, imem_wdata});
            wcyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 0; in_valid = 0; start = 0;
        repeat (n) tick();
        rst_n = 1;
    endtask

    task automatic go();
        start = 1; tick(); start = 0;
        wlog.delete(); wcyc.delete();
    endtask

    task automatic send(input logic [4:0] op, input logic [1:0] ra, input logic [1:0] rb,
                        input logic [3:0] imm, output bit first_try);
        bit a;
        int tries;
        a = 0;
        in_valid = 1; in_op = op; in_ra = ra; in_rb = rb; in_imm = imm;
        for (tries = 0; tries < 50; tries++) begin
            @(negedge clk);
            a = in_ready;
            tick();
            if (a) break;
        end
        first_try = a && (tries == 0);
        if (!a) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: op %0h never accepted (cycle %0d)", op, cyc);
        end
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget && !done && !err; i++) tick();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_in_ready"}, in_ready, 0);
        chk({nm, "_we"},       imem_we, 0);
        chk({nm, "_addr"},     imem_addr, 0);
        chk({nm, "_wdata"},    imem_wdata, 0);
        chk({nm, "_busy"},     busy, 0);
        chk({nm, "_done"},     done, 0);
        chk({nm, "_err"},      err, 0);
        chk({nm, "_code"},     err_code, 0);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit ft;
        int firsts;
        do_reset(2);
        @(negedge clk);
        chk_all_zero("reset");
        tick();

        // Program: seti 0101, add 01,10, halt
        go();
        send(5'b00110, 2'b00, 2'b00, 4'b0101, ft);
        send(5'b00000, 2'b01, 2'b10, 4'b0000, ft);
        send(5'b11010, 2'b00, 2'b00, 4'b0000, ft);
        in_valid = 0;
        wait_end(20);
        chk("p1_nwrites", wlog.size(), 3);
        chk("p1_w0", wlog[0], {8'd0, 9'b0_0110_0101});
        chk("p1_w1", wlog[1], {8'd1, 9'b0_0000_0110});
        chk("p1_w2", wlog[2], {8'd2, 9'b1_1010_0000});
        chk("p1_done", done, 1);

        // rsAdr / rsCnt encodings
        go();
        send(5'b00101, 2'b00, 2'b00, 4'b1111, ft);
        send(5'b01110, 2'b11, 2'b00, 4'b0000, ft);
        send(5'b11010, 2'b00, 2'b00, 4'b0000, ft);
        in_valid = 0;
        wait_end(20);
        chk("p2_w0", wlog[0], {8'd0, 9'b0_0101_0001});
        chk("p2_w1", wlog[1], {8'd1, 9'b0_1110_0000});

        // Six back-to-back words
        go();
        firsts = 0;
        for (int i = 0; i < 6; i++) begin
            send(5'(i + 7), 2'(i), 2'(i + 1), 4'(i), ft);
            if (ft) firsts++;
        end
        send(5'b11010, 2'b00, 2'b00, 4'b0000, ft);
        in_valid = 0;
        wait_end(30);
        chk("b2b_first_try", firsts, 6);
        chk("b2b_nwrites", wlog.size(), 7);
        for (int i = 0; i < 6; i++) chk("b2b_addr", wlog[i][16:9], i);
        chk("b2b_span", wcyc[5] - wcyc[0], 5);

        // Illegal opcode after two legal words
        go();
        send(5'd1, 2'd1, 2'd2, 4'd0, ft);
        send(5'd2, 2'd3, 2'd0, 4'd0, ft);
        send(5'b11101, 2'd0, 2'd0, 4'd0, ft);
        in_valid = 0;
        repeat (5) tick();
        chk("ill_err", err, 1);
        chk("ill_code", err_code, 2'b01);
        chk("ill_ready", in_ready, 0);
        chk("ill_nwrites", wlog.size(), 2);

        // Address overflow: 256 non-halt words
        go();
        for (int i = 0; i < 256; i++) send(5'd3, 2'(i), 2'(i >> 2), 4'd0, ft);
        in_valid = 0;
        wait_end(20);
        chk("ovf_nwrites", wlog.size(), 256);
        chk("ovf_last_addr", wlog[255][16:9], 255);
        chk("ovf_code", err_code, 2'b10);
        // Halt as word 256 lands exactly at the last address
        go();
        for (int i = 0; i < 255; i++) send(5'd3, 2'(i), 2'(i >> 2), 4'd0, ft);
        send(5'b11010, 2'd0, 2'd0, 4'd0, ft);
        in_valid = 0;
        wait_end(20);
        chk("full_done", done, 1);
        chk("full_err", err, 0);
        chk("full_last", wlog[255], {8'd255, 9'b1_1010_0000});

        // Reset mid-load
        go();
        send(5'd1, 2'd1, 2'd1, 4'd0, ft);
        send(5'd2, 2'd2, 2'd2, 4'd0, ft);
        send(5'd3, 2'd3, 2'd3, 4'd0, ft);
        in_valid = 0; rst_n = 0;
        tick();
        @(negedge clk);
        chk_all_zero("midrst");
        rst_n = 1;
        tick();
        wlog.delete();
        repeat (6) tick();
        chk("midrst_nowrites", wlog.size(), 0);
        go();
        send(5'd4, 2'd1, 2'd0, 4'd0, ft);
        send(5'b11010, 2'd0, 2'd0, 4'd0, ft);
        in_valid = 0;
        wait_end(20);
        chk("restart_addr0", wlog[0], {8'd0, 9'b0_0100_0100});

        // Randomized programs checked by the model every cycle
        for (int run = 0; run < 40; run++) begin
            int nw;
            go();
            nw = $urandom_range(1, 30);
            for (int k = 0; k < nw; k++) begin
                if ($urandom_range(0, 5) == 0) begin
                    in_valid = 0;
                    repeat ($urandom_range(1, 3)) tick();
                end
                if ($urandom_range(0, 12) == 0) begin
                    start = 1; tick(); start = 0;
                end
                if ($urandom_range(0, 60) == 0) begin
                    send(5'($urandom_range(27, 31)), 2'($urandom), 2'($urandom), 4'($urandom), ft);
                    break;
                end
                if ($urandom_range(0, 80) == 0) begin
                    in_valid = 0;
                    do_reset(1);
                    break;
                end
                send(5'($urandom_range(0, 25)), 2'($urandom), 2'($urandom), 4'($urandom), ft);
            end
            if (busy && !in_valid && m_mode == 0) begin
                tick();
            end
            if (m_mode == 1) send(5'b11010, 2'd0, 2'd0, 4'd0, ft);
            in_valid = 0;
            wait_end(100);
            repeat (2) tick();
        end

        in_valid = 0;
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  synchronous, active-low reset.
REQ-003 SHALL have ports: start  in  1  one-cycle pulse that begins a program load.
REQ-004 SHALL have ports: in_valid  in  1; in_ready  out  1  (source handshake).
REQ-005 SHALL have ports: in_op  in  5  opcode; in_ra  in  2; in_rb  in  2; in_imm  in  4.
REQ-006 SHALL have ports: imem_we  out  1; imem_addr  out  8; imem_wdata  out  9  (instruction-memory write port).
REQ-007 SHALL have ports: busy  out  1; done  out  1; err  out  1; err_code  out  2.
REQ-008 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of encoded-word buffer entries.

Function
REQ-009 SHALL encode imem_wdata[8:4] = in_op for every legal opcode.
REQ-010 SHALL encode R-class opcodes (00000-11001, except 00101, 00110, 01110, 11000 and 11010) with [3:2] = in_ra and [1:0] = in_rb.
REQ-011 SHALL encode I-class opcodes (00110 seti, 11000 jump) with [3:0] = in_imm.
REQ-012 SHALL encode 00101 (rsAdr) with [3:1] = 000 and [0] = in_imm[0].
REQ-013 SHALL encode Z-class opcodes (01110 rsCnt, 11010 halt) with [3:0] = 0000.
REQ-014 SHALL treat opcodes 11011-11111 as illegal.
REQ-015 SHALL implement FSM states IDLE, LOAD, DRAIN, DONE and ERR.
REQ-016 SHALL take these FSM transitions:
- IDLE/DONE/ERR --start--> LOAD: imem_addr = 0, FIFO cleared, done = 0, err = 0.
- start in LOAD or DRAIN: ignored.
REQ-017 SHALL drive in_ready = 1 only in LOAD with FIFO not full.
REQ-018 SHALL push the encoded word into the FIFO on in_valid & in_ready.
REQ-019 SHALL, on accepting halt, go to DRAIN, where in_ready = 0.
REQ-020 SHALL, on accepting an illegal opcode, go to ERR next cycle with err_code = 01, push nothing, and discard FIFO contents unwritten.
REQ-021 SHALL, in LOAD or DRAIN, pop one FIFO word per cycle when not empty.
REQ-022 SHALL register each popped word to imem_we = 1, imem_wdata = word, imem_addr = current address, then increment the address.
REQ-023 SHALL meet latency: a word accepted in cycle N appears on imem_we no earlier than N+1; an empty FIFO with a push in N writes in N+1.
REQ-024 SHALL allow push and pop in the same cycle when the FIFO is not full; occupancy is then unchanged.
REQ-025 SHALL, in DRAIN, go to DONE in the cycle after the halt word is written; done = 1 holds until the next start or reset.
REQ-026 SHALL, if a non-halt word is written at address 255, go to ERR with err_code = 10.
REQ-027 SHALL, if halt is written at address 255, go to DONE (no overflow).
REQ-028 SHALL drive busy = 1 in LOAD and DRAIN only.
REQ-029 SHALL keep err_code = 00 unless in ERR.
REQ-030 SHALL drive imem_we = 0 in IDLE, DONE and ERR.

Reset
REQ-031 SHALL, on rst_n = 0 at a clock edge, go to IDLE, empty the FIFO and set all outputs to 0 (in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, err_code).
REQ-032 SHALL, on a reset mid-load, abandon the FIFO contents with no further imem writes.

Verification
REQ-033 SHALL verify: start; send seti imm=0101, add ra=01 rb=10, halt -> writes 0_0110_0101 @0, 0_0000_0110 @1, 1_1010_0000 @2; then done = 1.
REQ-034 SHALL verify: rsAdr with imm=1111 -> 0_0101_0001; rsCnt with ra=11 -> 0_1110_0000.
REQ-035 SHALL verify: in_valid held with imem writes, 6 words back-to-back with FIFO_DEPTH = 4 -> in_ready never drops, one write per cycle, addresses 0-5 in order.
REQ-036 SHALL verify: opcode 11101 after 2 legal words -> err = 1, err_code = 01, no further writes, in_ready = 0.
REQ-037 SHALL verify: 256 non-halt words -> 256 writes, then err_code = 10; a repeat run with halt as word 256 -> done = 1, err = 0.
REQ-038 SHALL verify: rst_n = 0 with 3 words buffered -> next cycle all outputs 0, no imem_we thereafter, and a following start restarts at address 0.
